// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// State encoding, opcode map, legality check and trap causes.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_e;

  localparam logic [5:0] OP_LD     = 6'h18;
  localparam logic [5:0] OP_ST     = 6'h19;
  localparam logic [5:0] OP_JMP    = 6'h1B;
  localparam logic [5:0] OP_BEQ    = 6'h1C;
  localparam logic [5:0] OP_BNE    = 6'h1D;
  localparam logic [5:0] OP_LDR    = 6'h1F;
  localparam logic [5:0] OP_ADD    = 6'h20;
  localparam logic [5:0] OP_SUB    = 6'h21;
  localparam logic [5:0] OP_MUL    = 6'h22;
  localparam logic [5:0] OP_CMPEQ  = 6'h24;
  localparam logic [5:0] OP_CMPLT  = 6'h25;
  localparam logic [5:0] OP_CMPLE  = 6'h26;
  localparam logic [5:0] OP_AND    = 6'h28;
  localparam logic [5:0] OP_OR     = 6'h29;
  localparam logic [5:0] OP_XOR    = 6'h2A;
  localparam logic [5:0] OP_SHL    = 6'h2C;
  localparam logic [5:0] OP_SHR    = 6'h2D;
  localparam logic [5:0] OP_SRA    = 6'h2E;
  localparam logic [5:0] OP_ADDC   = 6'h30;
  localparam logic [5:0] OP_SUBC   = 6'h31;
  localparam logic [5:0] OP_MULC   = 6'h32;
  localparam logic [5:0] OP_CMPEQC = 6'h34;
  localparam logic [5:0] OP_CMPLTC = 6'h35;
  localparam logic [5:0] OP_CMPLEC = 6'h36;
  localparam logic [5:0] OP_ANDC   = 6'h38;
  localparam logic [5:0] OP_ORC    = 6'h39;
  localparam logic [5:0] OP_XORC   = 6'h3A;
  localparam logic [5:0] OP_SHLC   = 6'h3C;
  localparam logic [5:0] OP_SHRC   = 6'h3D;
  localparam logic [5:0] OP_SRAC   = 6'h3E;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_IMEM_TO = 2'b10;
  localparam logic [1:0] TC_DMEM_TO = 2'b11;

  function automatic logic op_legal(
    input logic [5:0] op
  );
    unique case (op)
      OP_LD, OP_ST, OP_JMP, OP_BEQ,
      OP_BNE, OP_LDR,
      OP_ADD, OP_SUB, OP_MUL,
      OP_CMPEQ, OP_CMPLT, OP_CMPLE,
      OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_SRA,
      OP_ADDC, OP_SUBC, OP_MULC,
      OP_CMPEQC, OP_CMPLTC, OP_CMPLEC,
      OP_ANDC, OP_ORC, OP_XORC,
      OP_SHLC, OP_SHRC, OP_SRAC:
        op_legal = 1'b1;
      default:
        op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Handshake wait counter shared by instruction fetch and data access.
// Flags timeout on the last cycle an ack may still be accepted.
module seq_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign timeout = (cnt_q == TW'(TIMEOUT - 1));

  // Clear outside a request, count each waiting cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bus-timeout traps.
// Define PERF_CNT_EN to add the cycle_cnt and instret counters.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ir,
  input  logic            moe,
  input  logic            mwr,
  input  logic            werf,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic            pc_en,
  output logic            busy,
  output logic            trap,
`ifdef PERF_CNT_EN
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instret,
`endif
  output logic [1:0]      trap_cause
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic            mwr_q, mwr_d;
  logic            werf_q, werf_d;
  logic            trap_q, trap_d;
  logic [1:0]      cause_q, cause_d;
  logic            wait_clr;
  logic            wait_en;
  logic            wait_to;

  assign wait_clr = !((state_q == FETCH) ||
                      (state_q == MEM));
  assign wait_en  = ((state_q == FETCH) && !imem_ack) ||
                    ((state_q == MEM) && !dmem_ack);

  seq_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .TW     (TW)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wait_clr),
    .en     (wait_en),
    .timeout(wait_to)
  );

  // Next-state, instruction capture and trap bookkeeping.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    mwr_d   = mwr_q;
    werf_d  = werf_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end else if (wait_to) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = TC_IMEM_TO;
        end
      end
      DECODE: begin
        if (!op_legal(ir_q[XLEN-1 -: 6])) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = TC_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        mwr_d   = mwr;
        werf_d  = werf;
        state_d = (moe || mwr) ? MEM : WB;
      end
      MEM: begin
        if (dmem_ack) begin
          state_d = WB;
        end else if (wait_to) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = TC_DMEM_TO;
        end
      end
      WB: begin
        state_d = run ? FETCH : IDLE;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      mwr_q   <= 1'b0;
      werf_q  <= 1'b0;
      trap_q  <= 1'b0;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      mwr_q   <= mwr_d;
      werf_q  <= werf_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  assign imem_req   = (state_q == FETCH);
  assign dmem_req   = (state_q == MEM);
  assign dmem_we    = (state_q == MEM) && mwr_q;
  assign rf_we      = (state_q == WB) && werf_q;
  assign pc_en      = (state_q == WB);
  assign busy       = (state_q != IDLE) &&
                      (state_q != TRAP);
  assign ir         = ir_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

`ifdef PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ret_q, ret_d;

  // Busy-cycle and retired-instruction counts.
  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (busy)  cyc_d = cyc_q + 32'd1;
    if (pc_en) ret_d = ret_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instret   = ret_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer.
// Directed vector table, hand sequences and randomized instructions.
module tb_instr_sequencer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        moe = 1'b0;
  logic        mwr = 1'b0;
  logic        werf = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we;
  logic        rf_we, pc_en, busy, trap;
  logic [31:0] ir;
  logic [1:0]  trap_cause;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret;
`endif

  instr_sequencer #(
    .XLEN   (32),
    .TIMEOUT(TO),
    .TW     (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .ir        (ir),
    .moe       (moe),
    .mwr       (mwr),
    .werf      (werf),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .rf_we     (rf_we),
    .pc_en     (pc_en),
    .busy      (busy),
    .trap      (trap),
`ifdef PERF_CNT_EN
    .cycle_cnt (cycle_cnt),
    .instret   (instret),
`endif
    .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] last_ir = '0;
  int          perf_busy = 0;
  int          perf_wb = 0;

  logic [5:0] legal_ops [30] = '{
    6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F,
    6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26,
    6'h28, 6'h29, 6'h2A, 6'h2C, 6'h2D, 6'h2E,
    6'h30, 6'h31, 6'h32, 6'h34, 6'h35, 6'h36,
    6'h38, 6'h39, 6'h3A, 6'h3C, 6'h3D, 6'h3E
  };

  typedef struct {
    logic [31:0] instr;
    int          iw;
    int          dw;
    bit          keep;
    int          exp_busy;
    int          exp_cause;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    for (int i = 0; i < 30; i++)
      if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    run      = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    last_ir   = '0;
    perf_busy = 0;
    perf_wb   = 0;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_strobes"},
        {imem_req, dmem_req, dmem_we,
         rf_we, pc_en, busy}, 6'b0);
  endtask

  // One instruction from FETCH to WB or TRAP, with model checks.
  task automatic do_instr(input  logic [31:0] instr,
                          input  int iw,
                          input  int dw,
                          input  bit keep,
                          input  bit noise,
                          output int busy_n,
                          output int cause_o);
    int ireq = 0, dreq = 0, dwe = 0;
    int rfw = 0, pce = 0, pc_at = 0;
    int icnt = 0, dcnt = 0, cyc = 0;
    int e_i, e_d, e_busy, e_cause, e_we;
    int e_rf, e_pc, e_cyc;
    bit done = 1'b0, acked = 1'b0;
    logic [31:0] e_ir;
    logic [5:0] op;
    bit legal, m_moe, m_mwr, m_werf, mem;
    op     = instr[31:26];
    legal  = is_legal(op);
    m_moe  = (op == 6'h18) || (op == 6'h1F);
    m_mwr  = (op == 6'h19);
    m_werf = !m_mwr;
    mem    = m_moe || m_mwr;
    if (iw >= TO) begin
      e_i = TO; e_d = 0; e_cause = 2;
      e_busy = TO; e_ir = last_ir;
    end else begin
      e_i = iw + 1; e_ir = instr;
      if (!legal) begin
        e_d = 0; e_cause = 1; e_busy = e_i + 1;
      end else if (mem && dw >= TO) begin
        e_d = TO; e_cause = 3; e_busy = e_i + 2 + TO;
      end else begin
        e_d = mem ? dw + 1 : 0; e_cause = 0;
        e_busy = e_i + 2 + e_d + 1;
      end
    end
    e_pc = (e_cause == 0) ? 1 : 0;
    e_rf = (e_pc == 1 && m_werf) ? 1 : 0;
    e_we = (mem && m_mwr) ? e_d : 0;
    imem_rdata = instr;
    moe  = m_moe;
    mwr  = m_mwr;
    werf = m_werf;
    run  = 1'b1;
    busy_n = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) busy_n++;
      if (imem_req) ireq++;
      if (dmem_req) dreq++;
      if (dmem_req && dmem_we) dwe++;
      if (rf_we) rfw++;
      if (pc_en) begin pce++; pc_at = busy_n; end
      if (pc_en || trap) done = 1'b1;
      if (imem_req) begin
        icnt++;
        imem_ack = (icnt == iw + 1);
        if (icnt == iw + 1) acked = 1'b1;
      end else begin
        imem_ack = noise ? 1'($urandom) : 1'b0;
      end
      if (dmem_req) begin
        dcnt++;
        dmem_ack = (dcnt == dw + 1);
      end else begin
        dmem_ack = noise ? 1'($urandom) : 1'b0;
      end
      if (acked && !keep && !imem_req) run = 1'b0;
    end
    chk("cycle_bound", done, 1'b1);
    chk("busy_cycles", busy_n, e_busy);
    chk("imem_req_cycles", ireq, e_i);
    chk("dmem_req_cycles", dreq, e_d);
    chk("dmem_we_cycles", dwe, e_we);
    chk("rf_we_pulses", rfw, e_rf);
    chk("pc_en_pulses", pce, e_pc);
    if (e_pc == 1) chk("wb_latency", pc_at, e_busy);
    chk("trap", trap, (e_cause != 0));
    chk("trap_cause", trap_cause, e_cause);
    chk("ir", ir, e_ir);
    e_cyc = perf_busy + busy_n - e_pc;
`ifdef PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt, e_cyc);
    chk("instret", instret, perf_wb);
`endif
    perf_busy += busy_n;
    perf_wb   += e_pc;
    last_ir  = e_ir;
    cause_o  = trap_cause;
  endtask

  task automatic post(input bit keep, input int c);
    if (c != 0) begin
      do_reset();
    end else if (!keep) begin
      @(posedge clk); #1;
      chk_quiet("idle_after_drop");
      @(posedge clk); #1;
      chk_quiet("idle_hold");
    end
  endtask

  vec_t vecs [12];
  int   b, c;

  initial begin
    vecs[0]  = '{32'h8000_0000, 0, 0, 1, 4, 0};
    vecs[1]  = '{32'h6000_0000, 0, 2, 1, 7, 0};
    vecs[2]  = '{32'h6400_0000, 0, 0, 1, 5, 0};
    vecs[3]  = '{32'h8000_1234, 3, 0, 1, 7, 0};
    vecs[4]  = '{32'h6400_0010, 0, 15, 1, 20, 0};
    vecs[5]  = '{32'h6000_0004, 15, 0, 1, 20, 0};
    vecs[6]  = '{32'h0000_0000, 0, 0, 1, 2, 1};
    vecs[7]  = '{32'h8000_0000, 16, 0, 1, 16, 2};
    vecs[8]  = '{32'h6000_0000, 0, 16, 1, 19, 3};
    vecs[9]  = '{32'h8000_0000, 0, 0, 0, 4, 0};
    vecs[10] = '{32'h7000_0000, 1, 0, 1, 5, 0};
    vecs[11] = '{32'hFC00_0000, 0, 0, 1, 2, 1};

    #2;
    chk_quiet("reset");
    chk("reset_trap", {trap, trap_cause}, 3'b0);
    chk("reset_ir", ir, 32'h0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      do_instr(vecs[i].instr, vecs[i].iw,
               vecs[i].dw, vecs[i].keep, 1'b0, b, c);
      chk($sformatf("vec%0d_busy", i), b,
          vecs[i].exp_busy);
      chk($sformatf("vec%0d_cause", i), c,
          vecs[i].exp_cause);
      post(vecs[i].keep, c);
    end

    do_instr(32'h0000_0000, 0, 0, 1, 1'b0, b, c);
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    b = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (pc_en || rf_we || imem_req || busy) b++;
    end
    chk("trap_strobes", b, 0);
    chk("trap_sticky", {trap, trap_cause}, 3'b101);
    do_reset();
    #1;
    chk("trap_cleared", {trap, trap_cause}, 3'b000);

    imem_rdata = 32'h6000_0000;
    moe = 1'b1; mwr = 1'b0; werf = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 20 && !dmem_req; i++) begin
      @(posedge clk); #1;
      imem_ack = imem_req;
    end
    chk("mem_reached", dmem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    chk("async_reset_ir", ir, 32'h0);
    do_reset();

    for (int k = 0; k < 80; k++) begin
      logic [31:0] ins;
      int r, iw, dw;
      bit keep;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0)
        ins[31:26] = legal_ops[$urandom_range(0, 29)];
      r  = $urandom_range(0, 9);
      iw = (r < 7) ? r % 4 : (r == 7 ? 15 : (r == 8 ? 16 : 2));
      r  = $urandom_range(0, 9);
      dw = (r < 7) ? r % 4 : (r == 7 ? 15 : (r == 8 ? 16 : 1));
      keep = 1'($urandom_range(0, 3) != 0);
      do_instr(ins, iw, dw, keep, 1'b1, b, c);
      post(keep, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
